// File: rtl/mileage_odometer_if.sv
// -----------------------------------------------------------------------------
// mileage_odometer_if
//
// Groups the motion-qualifier inputs and the odometer outputs of
// mileage_odometer into one bundle.
//
// Signals:
//   enable        : high while the car FSM is in its moving state
//   move_forward  : registered forward command from the car top level
//   move_backward : registered backward command from the car top level
//   clear         : synchronous clear of distance, prescaler and overflow
//   bcd           : packed BCD distance, digit 0 in [3:0]
//   unit_pulse    : one-cycle pulse coincident with each new bcd value
//   running       : high while the odometer is accumulating
//   overflow      : sticky flag, set when the count passes its maximum
//
// Modports:
//   master : car-side producer of the motion inputs, consumer of the outputs
//   slave  : the odometer itself
// -----------------------------------------------------------------------------
interface mileage_odometer_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  enable;
  logic                  move_forward;
  logic                  move_backward;
  logic                  clear;
  logic [4*DIGITS-1:0]   bcd;
  logic                  unit_pulse;
  logic                  running;
  logic                  overflow;

  modport master (
    output enable,
    output move_forward,
    output move_backward,
    output clear,
    input  bcd,
    input  unit_pulse,
    input  running,
    input  overflow
  );

  modport slave (
    input  enable,
    input  move_forward,
    input  move_backward,
    input  clear,
    output bcd,
    output unit_pulse,
    output running,
    output overflow
  );
endinterface

// File: rtl/mileage_odometer.sv
// -----------------------------------------------------------------------------
// mileage_odometer
//
// Accumulates absolute travelled distance as a packed BCD odometer. Forward
// and reverse motion both add. A prescaler counts clk cycles of qualified
// motion; every TICKS_PER_UNIT such cycles the BCD value advances by one.
// The BCD vector drives the 7-segment display block directly.
//
// Parameters:
//   TICKS_PER_UNIT : clk cycles of valid motion per distance unit (>= 2)
//   DIGITS         : number of BCD digits (bcd width is 4*DIGITS)
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mileage_odometer_if.slave
//             enable, move_forward, move_backward, clear  (inputs)
//             bcd, unit_pulse, running, overflow          (outputs)
//
// Build option:
//   MILEAGE_SATURATE_EN : when defined, a unit completed at all-9s leaves the
//                         count at all-9s, sets overflow and parks the FSM in
//                         ST_FULL until clear or reset. When undefined the
//                         count wraps to zero and overflow sets (sticky).
// -----------------------------------------------------------------------------
module mileage_odometer #(
  parameter int unsigned TICKS_PER_UNIT = 100000000,
  parameter int unsigned DIGITS         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mileage_odometer_if.slave bus
);

  // Prescaler width; a floor of 1 bit keeps the vector legal for small counts.
  localparam int unsigned PW = (TICKS_PER_UNIT > 2) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_UNIT - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

`ifdef MILEAGE_SATURATE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  state_t              state;
  logic [PW-1:0]       presc;
  logic [4*DIGITS-1:0] bcd_q;
  logic                pulse_q;
  logic                running_q;
  logic                overflow_q;

  logic                go;
  logic                terminal;
  logic [4*DIGITS-1:0] bcd_inc;
  logic                all_nines;

  // Both directions at once, or neither, is not motion.
  assign go = bus.enable & (bus.move_forward ^ bus.move_backward);

  // Only a prescaler already accumulating in ST_RUN can complete a unit.
  assign terminal = (state == ST_RUN) && go && (presc == TERM);

  // Single-cycle ripple-carry BCD increment. The carry out of the top digit
  // is exactly the all-9s condition, so it doubles as the overflow detector.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    bcd_inc = '0;
    carry   = 1'b1;
    digit   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (digit >= 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = digit + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        bcd_inc[4*i +: 4] = digit;
      end
    end
    all_nines = carry;
  end

  // FSM, prescaler and all outputs share one register block so that running,
  // unit_pulse and bcd change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      presc      <= '0;
      bcd_q      <= '0;
      pulse_q    <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      // Takes priority over a coincident terminal count: no pulse, no carry.
      state      <= ST_IDLE;
      presc      <= '0;
      bcd_q      <= '0;
      pulse_q    <= 1'b0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Prescaler holds so fractional distance survives a stop. The
          // transition cycle itself does not advance the prescaler.
          if (go) begin
            state     <= ST_RUN;
            running_q <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!go) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
          end else if (terminal) begin
            presc <= '0;
`ifdef MILEAGE_SATURATE_EN
            if (all_nines) begin
              // The count cannot change, so no pulse accompanies saturation.
              overflow_q <= 1'b1;
              state      <= ST_FULL;
              running_q  <= 1'b0;
            end else begin
              bcd_q   <= bcd_inc;
              pulse_q <= 1'b1;
            end
`else
            bcd_q   <= bcd_inc;
            pulse_q <= 1'b1;
            if (all_nines) begin
              overflow_q <= 1'b1;
            end
`endif
          end else begin
            presc <= presc + ONE;
          end
        end

`ifdef MILEAGE_SATURATE_EN
        ST_FULL: begin
          // Parked until clear or reset; motion is ignored.
          presc     <= '0;
          running_q <= 1'b0;
        end
`endif

        default: begin
          state     <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bcd        = bcd_q;
  assign bus.unit_pulse = pulse_q;
  assign bus.running    = running_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_mileage_odometer.sv
module tb_mileage_odometer;

  localparam int unsigned TICKS  = 4;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned MAXV   = 9999;

  logic clk;
  logic rst_n;

  mileage_odometer_if #(.DIGITS(DIGITS)) bus ();

  mileage_odometer #(
    .TICKS_PER_UNIT(TICKS),
    .DIGITS        (DIGITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests;
  int unsigned fails;

  // Reference model: whole units travelled, motion cycles banked towards the
  // next unit, and whether the odometer has already spun up.
  int unsigned m_dist;
  int unsigned m_frac;
  bit          m_run;
  bit          m_full;
  bit          m_pulse;
  bit          m_ovf;

  typedef struct {
    logic        en;
    logic        f;
    logic        b;
    logic        c;
    logic [15:0] bcd;
    logic        pulse;
    logic        run;
    logic        ovf;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dist  = 0;
    m_frac  = 0;
    m_run   = 0;
    m_full  = 0;
    m_pulse = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(input bit en, input bit f, input bit b, input bit c);
    bit go;
    go      = en & (f ^ b);
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (m_full) begin
      // parked
    end else if (!m_run) begin
      m_run = go;
    end else if (!go) begin
      m_run = 0;
    end else begin
      m_frac++;
      if (m_frac == TICKS) begin
        m_frac = 0;
        if (m_dist == MAXV) begin
          m_ovf = 1;
`ifdef MILEAGE_SATURATE_EN
          m_full = 1;
          m_run  = 0;
`else
          m_dist  = 0;
          m_pulse = 1;
`endif
        end else begin
          m_dist++;
          m_pulse = 1;
        end
      end
    end
  endtask

  // Called at a negedge; drives inputs, clocks one edge, returns at the next negedge.
  task automatic step(input logic en, input logic f, input logic b, input logic c);
    bus.enable        = en;
    bus.move_forward  = f;
    bus.move_backward = b;
    bus.clear         = c;
    @(posedge clk);
    model_edge(en, f, b, c);
    @(negedge clk);
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.bcd, bus.unit_pulse, bus.running, bus.overflow});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({to_bcd(m_dist), m_pulse, m_run, m_ovf});
  endfunction

  initial begin
    int unsigned n;
    int unsigned npulse;
    int unsigned gap;
    logic en, f, b, c;

    tests = 0;
    fails = 0;
    model_reset();
    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.move_forward  = 1'b0;
    bus.move_backward = 1'b0;
    bus.clear         = 1'b0;

    // Motion, direction qualification, stop/resume and clear-vs-terminal.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_bcd", 64'(bus.bcd), 64'h0);
    check("reset_pulse", 64'(bus.unit_pulse), 64'h0);
    check("reset_running", 64'(bus.running), 64'h0);
    check("reset_overflow", 64'(bus.overflow), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].f, tbl[i].b, tbl[i].c);
      check($sformatf("vec%0d", i), dut_vec(),
            64'({tbl[i].bcd, tbl[i].pulse, tbl[i].run, tbl[i].ovf}));
    end

    // Ten consecutive units, each exactly TICKS cycles apart
    npulse = 0;
    gap    = 0;
    n      = 0;
    while (npulse < 10 && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
      gap++;
      if (bus.unit_pulse) begin
        npulse++;
        check($sformatf("pulse_gap%0d", npulse), 64'(gap), 64'(TICKS));
        check($sformatf("pulse_bcd%0d", npulse), 64'(bus.bcd), 64'(to_bcd(npulse)));
        gap = 0;
      end
    end
    check("ten_pulses", 64'(npulse), 64'd10);
    check("bcd_after_ten", 64'(bus.bcd), 64'h0010);

    // Stop mid-unit: prescaler is retained, resume costs only the restart cycle
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("stopped_running", 64'(bus.running), 64'h0);
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end while (!bus.unit_pulse && n < 20);
    check("resume_latency", 64'(n), 64'd3);
    check("resume_bcd", 64'(bus.bcd), 64'h0011);

    // Asynchronous reset between edges
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({bus.bcd, bus.unit_pulse, bus.running, bus.overflow}), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      n++;
    end while (!bus.unit_pulse && n < 20);
    check("post_reset_latency", 64'(n), 64'(TICKS + 1));
    check("post_reset_bcd", 64'(bus.bcd), 64'h0001);

    // Run up to all-9s, then one more unit
    n = 0;
    while (bus.bcd !== 16'h9999 && n < 45000) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("preload_9999", dut_vec(), model_vec());
    for (int i = 0; i < int'(TICKS); i++) step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef MILEAGE_SATURATE_EN
    check("sat_bcd", 64'(bus.bcd), 64'h9999);
    check("sat_ovf", 64'(bus.overflow), 64'h1);
    check("sat_running", 64'(bus.running), 64'h0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (bus.unit_pulse) npulse++;
    end
    check("sat_no_pulses", 64'(npulse), 64'h0);
    check("sat_hold", dut_vec(), 64'({16'h9999, 1'b0, 1'b0, 1'b1}));
`else
    check("wrap_vec", dut_vec(), 64'({16'h0000, 1'b1, 1'b1, 1'b1}));
    for (int i = 0; i < int'(TICKS); i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ovf_sticky", dut_vec(), 64'({16'h0001, 1'b1, 1'b1, 1'b1}));
`endif
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_vec", dut_vec(), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      f  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 99) == 0);
      step(en, f, b, c);
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mileage_odometer.md
Name: mileage_odometer

Overview:
- Downstream consumer of the car top level's registered motion outputs (move_forward, move_backward) and its moving-state indication.
- Accumulates travelled distance as a packed BCD odometer.
- The BCD vector feeds the 7-segment display block directly, so no binary-to-BCD conversion is needed there.
- Distance is absolute: forward and reverse travel both add.

Parameters:
- TICKS_PER_UNIT, 100000000: clk cycles of valid motion per distance unit (1 unit/s at 100 MHz); must be ≥2.
- DIGITS, 8: number of BCD digits; output width is 4*DIGITS.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: high while the car FSM is in the moving state.
- move_forward, input, 1: registered forward command from the car top level.
- move_backward, input, 1: registered backward command from the car top level.
- clear, input, 1: synchronous clear of distance, prescaler and overflow. Driven from the power-off event or a user button.
- bcd, output, 4*DIGITS: packed BCD distance; digit 0 (least significant) is in [3:0].
- unit_pulse, output, 1: one-cycle pulse, high in the same cycle the new bcd value first appears.
- running, output, 1: high while the FSM is in ST_RUN.
- overflow, output, 1: sticky flag, set when the count passes its maximum.

Behaviour:
- Reset (rst_n low, asynchronous): bcd=0, prescaler=0, unit_pulse=0, running=0, overflow=0, FSM=ST_IDLE.
- Motion qualifier: go = enable & (move_forward ^ move_backward). Both directions asserted, or neither, means no motion.
- FSM states: ST_IDLE, ST_RUN, ST_FULL. ST_FULL exists only with the optional feature.
- ST_IDLE:
  - Prescaler holds its value; fractional distance is retained across stops.
  - go=1 → ST_RUN on the next edge.
- ST_RUN:
  - Prescaler increments each cycle while go=1.
  - go=0 → ST_IDLE; the prescaler holds.
- Terminal count: when the prescaler = TICKS_PER_UNIT-1 and go=1 in the same cycle:
  - prescaler → 0.
  - bcd increments by 1.
  - unit_pulse=1 for exactly that one registered cycle.
- Latency:
  - ST_IDLE→ST_RUN costs one cycle, during which the prescaler does not advance.
  - From continuous go asserted in ST_IDLE, the first unit_pulse arrives after TICKS_PER_UNIT+1 edges.
- BCD increment:
  - Ripple carry across all digits in a single cycle.
  - A digit at 9 becomes 0 and carries into the next digit.
  - No digit may ever hold a value of 10–15.
- Wrap (feature off): all digits at 9 → all 0, and overflow sets (sticky).
- clear:
  - bcd=0, prescaler=0, overflow=0, unit_pulse=0, FSM=ST_IDLE, all on the next edge.
  - clear has priority over a simultaneous terminal count; no pulse is emitted.
- enable dropping mid-unit: the prescaler freezes and no pulse is emitted. Counting resumes from the frozen value.
- Reset asserted mid-operation: immediate return to reset values; no partial state is retained.
- running is registered and equals (FSM==ST_RUN).

Optional Feature:
- Macro: MILEAGE_SATURATE_EN.
- Defined:
  - A terminal count at all-9s leaves bcd at all-9s, sets overflow and enters ST_FULL.
  - In ST_FULL, go is ignored, the prescaler is held at 0 and unit_pulse stays low.
  - Only clear (→ST_IDLE) or reset leaves ST_FULL.
  - running=0 in ST_FULL.
- Undefined: wrap-to-zero behaviour as above; ST_FULL is not built.

Test Plan (TICKS_PER_UNIT=4, DIGITS=4):
1. Reset release, then enable=1, move_forward=1 held → running=1 after one edge; unit_pulse every 4 cycles; bcd=0x0001, 0x0002, …; after 10 pulses bcd=0x0010.
2. enable=1 with move_forward=move_backward=1, then with both 0 → no counting, running=0, bcd unchanged. Then move_backward=1 alone → counts identically to forward.
3. Run 2 ticks into a unit, drop enable for 20 cycles, re-enable → the next pulse arrives 1+2 cycles after re-enable, not 4.
4. Preload to 0x9999 by running, then one more unit → default build: bcd=0x0000, overflow=1. MILEAGE_SATURATE_EN build: bcd stays 0x9999, overflow=1, and no further pulses for 40 cycles of go.
5. Assert clear in the same cycle as a terminal count → bcd=0x0000, unit_pulse=0, overflow=0, FSM=ST_IDLE.
6. Assert rst_n low asynchronously mid-count (between edges) → all outputs 0 immediately; counting restarts from prescaler 0 after release.
